// File: rtl/muldiv_issue_ctrl.sv
// EX-stage sequencer for the RV32M multiply/divide unit: latches one op, drives the
// unit's start/operand handshake, returns the result with a done pulse, handles flush and timeout.
module muldiv_issue_ctrl #(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic [2:0]       funct3_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [31:0]      result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             err_o,
  output logic             md_start_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  output logic [2:0]       md_funct3_o,
  input  logic [31:0]      md_result_i,
  input  logic             md_ready_i
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    ABORT
  } state_t;

  localparam logic [6:0] TO_LAST = 7'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic             accept;
  logic             capture;
  logic             timeout;
  logic [6:0]       wait_cnt;
  logic [TAG_W-1:0] tag_q;

  // RELEASE also accepts, so a stalled op issues in the done cycle of the previous one
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (valid_i && !flush_i) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = flush_i ? ABORT : WAIT;
      WAIT: begin
        if (flush_i) begin
          state_d = ABORT;
        end else if (md_ready_i) begin
          capture = 1'b1;
          state_d = RELEASE;
        end else if (wait_cnt == TO_LAST) begin
          timeout = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT:   if (md_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

  // Operands stay put until the next accept; the unit decodes its result from them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      md_start_o  <= 1'b0;
      done_o      <= 1'b0;
      md_op_a_o   <= '0;
      md_op_b_o   <= '0;
      md_funct3_o <= '0;
      tag_q       <= '0;
      tag_o       <= '0;
      result_o    <= '0;
      err_o       <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      md_start_o <= (state_d == ISSUE) || (state_d == WAIT);
      done_o     <= capture;
      if (accept) begin
        md_op_a_o   <= op_a_i;
        md_op_b_o   <= op_b_i;
        md_funct3_o <= funct3_i;
        tag_q       <= tag_i;
      end
      if (capture) begin
        result_o <= md_result_i;
        tag_o    <= tag_q;
      end
      if (timeout) err_o <= 1'b1;
      if (state_q == ISSUE) begin
        wait_cnt <= '0;
      end else if (state_q == WAIT && wait_cnt != 7'h7f) begin
        wait_cnt <= wait_cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: behavioural mult/div unit, per-op timeline model
// compared every cycle, plus literal result checks for the directed cases.
module tb_muldiv_issue_ctrl;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1 << 30;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic [31:0]      op_a_i;
  logic [31:0]      op_b_i;
  logic [2:0]       funct3_i;
  logic [TAG_W-1:0] tag_i;
  logic             flush_i;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      result_o;
  logic [TAG_W-1:0] tag_o;
  logic             err_o;
  logic             md_start_o;
  logic [31:0]      md_op_a_o;
  logic [31:0]      md_op_b_o;
  logic [2:0]       md_funct3_o;
  logic [31:0]      md_result_i;
  logic             md_ready_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  muldiv_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .funct3_i(funct3_i), .tag_i(tag_i), .flush_i(flush_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .tag_o(tag_o), .err_o(err_o),
    .md_start_o(md_start_o), .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
    .md_funct3_o(md_funct3_o), .md_result_i(md_result_i), .md_ready_i(md_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference RV32M semantics, including the divide-by-zero and overflow cases
  function automatic logic [31:0] rv_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = int'(a);
    ib = int'(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Mult/div unit: single-cycle multiply, 32 calc cycles for divide, optional hang
  typedef enum logic [1:0] {U_IDLE, U_CALC, U_DONE, U_HUNG} ustate_t;
  ustate_t ust;
  int      ucnt;
  logic    stuck;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ust  <= U_IDLE;
      ucnt <= 0;
    end else begin
      case (ust)
        U_IDLE: if (md_start_o) begin
          if (stuck) ust <= U_HUNG;
          else if (md_funct3_o[2]) begin ust <= U_CALC; ucnt <= 0; end
          else ust <= U_DONE;
        end
        U_CALC: if (ucnt == 31) ust <= U_DONE; else ucnt <= ucnt + 1;
        U_DONE: if (!md_start_o) ust <= U_IDLE;
        default: if (!stuck && !md_start_o) ust <= U_IDLE;
      endcase
    end
  end

  assign md_ready_i  = (ust == U_IDLE) || (ust == U_DONE) || (ust == U_HUNG && !stuck);
  assign md_result_i = (ust == U_DONE) ? rv_m(md_funct3_o, md_op_a_o, md_op_b_o) : 32'hDEADBEEF;

  // Timeline of each accepted op, expressed in absolute cycle numbers
  typedef struct {
    int               acc;
    int               start_end;
    int               busy_end;
    int               done_cyc;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       f3;
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } op_rec_t;

  op_rec_t ops[$];
  int      free_cyc = 0;
  int      err_from = NEVER;
  logic    model_on = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    logic exp_busy, exp_start, exp_done, in_op;
    logic [31:0] exp_res, exp_a, exp_b;
    logic [2:0] exp_f3;
    logic [TAG_W-1:0] exp_tag;
    if (model_on && !rst) begin
      exp_busy = 1'b0; exp_start = 1'b0; exp_done = 1'b0; in_op = 1'b0;
      exp_res = '0; exp_a = '0; exp_b = '0; exp_f3 = '0; exp_tag = '0;
      for (int i = 0; i < ops.size(); i++) begin
        if (cyc > ops[i].acc && cyc <= ops[i].busy_end) begin
          exp_busy = 1'b1;
          in_op    = 1'b1;
          exp_a    = ops[i].a;
          exp_b    = ops[i].b;
          exp_f3   = ops[i].f3;
        end
        if (cyc > ops[i].acc && cyc <= ops[i].start_end) exp_start = 1'b1;
        if (cyc == ops[i].done_cyc) begin
          exp_done = 1'b1;
          exp_res  = ops[i].res;
          exp_tag  = ops[i].tag;
        end
      end
      check_output("busy", 32'(busy_o), 32'(exp_busy));
      check_output("md_start", 32'(md_start_o), 32'(exp_start));
      check_output("done", 32'(done_o), 32'(exp_done));
      check_output("err", 32'(err_o), 32'(cyc >= err_from));
      if (exp_done) begin
        check_output("result", result_o, exp_res);
        check_output("tag", 32'(tag_o), 32'(exp_tag));
      end
      if (in_op) begin
        check_output("md_op_a", md_op_a_o, exp_a);
        check_output("md_op_b", md_op_b_o, exp_b);
        check_output("md_funct3", 32'(md_funct3_o), 32'(exp_f3));
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // kind 0: runs to completion, 1: flushed in WAIT cycle 10, 2: unit hangs until cycle 80
  task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [TAG_W-1:0] t, input int kind, output int acc);
    op_rec_t r;
    int lat;
    acc = (cyc > free_cyc) ? cyc : free_cyc;
    lat = f3[2] ? 35 : 3;
    valid_i = 1'b1; op_a_i = a; op_b_i = b; funct3_i = f3; tag_i = t;
    r.acc = acc; r.a = a; r.b = b; r.f3 = f3; r.tag = t; r.res = rv_m(f3, a, b);
    case (kind)
      0: begin
        r.start_end = acc + lat - 1; r.busy_end = acc + lat; r.done_cyc = acc + lat;
        free_cyc = acc + lat;
      end
      1: begin
        r.start_end = acc + 10; r.busy_end = acc + 34; r.done_cyc = -1;
        free_cyc = acc + 35;
      end
      default: begin
        r.start_end = acc + 1 + TIMEOUT; r.busy_end = acc + 80; r.done_cyc = -1;
        free_cyc = acc + 81;
        err_from = acc + 2 + TIMEOUT;
      end
    endcase
    ops.push_back(r);
    wait_to(acc + 1);
    valid_i = 1'b0;
  endtask

  initial begin
    int acc, acc2;
    rst = 1'b1; valid_i = 1'b0; op_a_i = '0; op_b_i = '0; funct3_i = '0; tag_i = '0;
    flush_i = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy_o), 32'd0);
    check_output("reset_start", 32'(md_start_o), 32'd0);
    check_output("reset_done", 32'(done_o), 32'd0);
    check_output("reset_err", 32'(err_o), 32'd0);
    check_output("reset_result", result_o, 32'd0);
    check_output("reset_op_a", md_op_a_o, 32'd0);
    rst = 1'b0;
    free_cyc = cyc;
    model_on = 1'b1;
    @(negedge clk);

    // MUL 7*6, with a flush landing in the done cycle
    apply_stimulus(3'b000, 32'd7, 32'd6, 5'd3, 0, acc);
    wait_to(acc + 3);
    flush_i = 1'b1;
    check_output("mul_done_lit", 32'(done_o), 32'd1);
    check_output("mul_result_lit", result_o, 32'd42);
    check_output("mul_tag_lit", 32'(tag_o), 32'd3);
    @(negedge clk);
    flush_i = 1'b0;
    check_output("mul_busy_after_lit", 32'(busy_o), 32'd0);

    // valid together with flush in IDLE must not be accepted
    valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check_output("idle_flush_busy_lit", 32'(busy_o), 32'd0);

    // DIVU then REM presented while busy
    apply_stimulus(3'b101, 32'd100, 32'd7, 5'd1, 0, acc);
    apply_stimulus(3'b110, 32'hFFFFFFF9, 32'd2, 5'd2, 0, acc2);
    check_output("b2b_accept_lit", 32'(acc2 - acc), 32'd35);
    wait_to(acc + 35);
    check_output("divu_result_lit", result_o, 32'd14);
    wait_to(acc2 + 35);
    check_output("rem_result_lit", result_o, 32'hFFFFFFFF);

    // divide and remainder by zero
    apply_stimulus(3'b100, 32'h12345678, 32'd0, 5'd4, 0, acc);
    wait_to(acc + 35);
    check_output("div0_result_lit", result_o, 32'hFFFFFFFF);
    apply_stimulus(3'b110, 32'h12345678, 32'd0, 5'd5, 0, acc);
    wait_to(acc + 35);
    check_output("rem0_result_lit", result_o, 32'h12345678);

    // flush in WAIT cycle 10 of a DIV, then MUL 3*5
    apply_stimulus(3'b100, 32'd1000, 32'd3, 5'd7, 1, acc);
    wait_to(acc + 10);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    wait_to(acc + 34);
    check_output("flush_busy_hold_lit", 32'(busy_o), 32'd1);
    apply_stimulus(3'b000, 32'd3, 32'd5, 5'd8, 0, acc);
    wait_to(acc + 3);
    check_output("mul35_result_lit", result_o, 32'd15);
    @(negedge clk);

    // unit hangs after start: timeout, sticky err, ABORT until ready returns
    stuck = 1'b1;
    apply_stimulus(3'b000, 32'd9, 32'd9, 5'd10, 2, acc);
    wait_to(acc + 1 + TIMEOUT);
    check_output("timeout_err_before_lit", 32'(err_o), 32'd0);
    @(negedge clk);
    check_output("timeout_err_lit", 32'(err_o), 32'd1);
    wait_to(acc + 80);
    stuck = 1'b0;
    check_output("timeout_abort_busy_lit", 32'(busy_o), 32'd1);
    wait_to(acc + 82);
    check_output("timeout_err_sticky_lit", 32'(err_o), 32'd1);

    // reset in cycle 12 of a DIV
    apply_stimulus(3'b100, 32'd50, 32'd5, 5'd11, 0, acc);
    wait_to(acc + 12);
    model_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_output("rst_busy_lit", 32'(busy_o), 32'd0);
    check_output("rst_start_lit", 32'(md_start_o), 32'd0);
    check_output("rst_err_lit", 32'(err_o), 32'd0);
    check_output("rst_result_lit", result_o, 32'd0);
    check_output("rst_op_a_lit", md_op_a_o, 32'd0);
    check_output("rst_tag_lit", 32'(tag_o), 32'd0);
    ops.delete();
    err_from = NEVER;
    @(negedge clk);
    rst = 1'b0;
    free_cyc = cyc;
    model_on = 1'b1;
    @(negedge clk);

    // MULHU 0xFFFFFFFF * 0xFFFFFFFF
    apply_stimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 0, acc);
    wait_to(acc + 3);
    check_output("mulhu_result_lit", result_o, 32'hFFFFFFFE);
    wait_to(acc + 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
EX-stage sequencer that feeds the RV32M multiply/divide unit. It accepts one M-extension op from the EX pipeline, latches its operands, funct3 and destination tag, and drives the unit's start/operand interface with the hold-stable timing the unit requires. It captures the unit's result and returns it to the pipeline with a one-cycle done pulse. While an op is outstanding it stalls the pipeline, and it handles flush and hang-timeout.

Parameters:
TAG_W, 5, width of destination register tag carried with each op
TIMEOUT, 64, max cycles in WAIT before the op is aborted and err_o is set (must be >= 40)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_i  in  1  EX presents an M-extension op this cycle
op_a_i  in  32  rs1 value
op_b_i  in  32  rs2 value
funct3_i  in  3  RV32M funct3 (000 MUL ... 111 REMU)
tag_i  in  TAG_W  destination register index
flush_i  in  1  pipeline flush; kills the outstanding/incoming op
busy_o  out  1  op outstanding; EX must stall and hold valid_i
done_o  out  1  one-cycle pulse: result_o/tag_o valid
result_o  out  32  captured result
tag_o  out  TAG_W  tag of the completed op
err_o  out  1  sticky timeout flag; cleared only by rst
md_start_o  out  1  start to mult/div unit
md_op_a_o  out  32  operand A to unit (held stable)
md_op_b_o  out  32  operand B to unit (held stable)
md_funct3_o  out  3  funct3 to unit (held stable)
md_result_i  in  32  unit result
md_ready_i  in  1  unit ready (high in its idle and done states)

Behaviour:
- Reset: state=IDLE; all outputs 0, including md_op_*, md_funct3_o, result_o, tag_o and err_o.
- States: IDLE, ISSUE, WAIT, RELEASE, ABORT. busy_o = (state != IDLE). md_start_o = 1 only in ISSUE and WAIT; it is a registered output.
- IDLE: if valid_i & !flush_i, latch op_a/op_b/funct3/tag into md_op_*/md_funct3_o/tag register, then go to ISSUE. valid_i & flush_i is ignored.
- ISSUE (1 cycle): md_start_o=1. md_ready_i is ignored, because the unit is still idle and asserts ready. Next: WAIT, or ABORT if flush_i.
- WAIT: md_start_o=1. Transitions, in priority order:
  - flush_i: go to ABORT.
  - md_ready_i: capture md_result_i into result_o, copy the tag to tag_o, assert done_o for the next cycle, go to RELEASE.
  - WAIT cycle count reaches TIMEOUT: set err_o, go to ABORT, no done_o.
- RELEASE (1 cycle): md_start_o=0 so the unit leaves its done state. Go to IDLE.
- ABORT: md_start_o=0. Wait for md_ready_i=1, then go to IDLE. The unit returns to idle on that same edge. No done_o is issued for the killed op.
- flush_i in RELEASE or IDLE has no effect on a completed op; done_o still fires.
- md_op_*/md_funct3_o hold their values from latch until the next accept. This covers RELEASE, because the unit's result decode depends on the operands.
- Latency (accept edge = cycle 0):
  - MUL* ops capture in cycle 2; done_o is high in cycle 3.
  - DIV/DIVU/REM/REMU: the unit needs 32 calc cycles, so capture is in cycle 34 and done_o is high in cycle 35.
  - The earliest next accept is the edge ending cycle 3 (mul) or 35 (div), i.e. the done_o cycle.
- WAIT counter: 7-bit. It clears on entry to WAIT and saturates.
- rst mid-op: everything returns to the reset state immediately. The unit shares rst, so no drain is needed.

Test Plan:
- MUL: op_a=7, op_b=6, funct3=000, tag=3 -> done_o pulses 3 cycles after accept, result_o=42, tag_o=3; busy_o high for exactly 3 cycles.
- DIVU then REM back-to-back:
  - DIVU 100/7 -> result_o=14 with done_o at cycle 35.
  - REM 0xFFFFFFF9 % 2, presented while busy and accepted in the done cycle -> result_o=0xFFFFFFFF.
  - md_start_o is low in each RELEASE cycle.
- DIV by zero: 0x12345678 / 0 -> result_o=0xFFFFFFFF; REM by zero returns 0x12345678.
- Flush in WAIT at cycle 10 of a DIV -> no done_o; busy_o stays high until the unit's ready returns, then drops. A MUL issued afterwards (3*5) yields 15 correctly.
- Timeout: model unit with md_ready_i stuck low after start -> after 64 WAIT cycles err_o=1 (sticky); state is ABORT until md_ready_i=1; no done_o.
- Assert rst mid-DIV (cycle 12) -> all outputs 0 immediately and state IDLE; a fresh MULHU 0xFFFFFFFF*0xFFFFFFFF after release -> result_o=0xFFFFFFFE.
